// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA/DVI raster timing generator.
// Produces hsync/vsync/video_on and pixel coordinates for a mode set by
// parameters, advancing one position per cycle with pix_ce=1. A run/stop
// control stops only at the frame boundary. Optional macro
// VGA_FRAME_CNT_EN adds a 16-bit frame counter output (frame_cnt).
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned CW       = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pix_ce,
  input  logic          run,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic [CW-1:0] pixel_x,
  output logic [CW-1:0] pixel_y,
  output logic          line_start,
  output logic          frame_start,
  output logic          busy
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [15:0]   frame_cnt
`endif
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT_C  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT_C  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  state_t        next_state;
  logic [CW-1:0] nx;
  logic [CW-1:0] ny;
  logic          go;

  // Next raster position and state; every output is then registered from
  // this one position so sync, blanking and coordinates never skew.
  always_comb begin
    next_state = state;
    nx         = '0;
    ny         = '0;
    case (state)
      IDLE: begin
        if (run) next_state = RUN;
      end
      RUN: begin
        nx = pixel_x + 1'b1;
        ny = pixel_y;
        if (pixel_x == H_LAST) begin
          nx = '0;
          if (pixel_y == V_LAST) begin
            ny = '0;
            if (!run) next_state = IDLE;
          end else begin
            ny = pixel_y + 1'b1;
          end
        end
      end
    endcase
    go = (next_state == RUN);
  end

  // State and registered outputs; everything holds on cycles without pix_ce.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      video_on    <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
    end else if (pix_ce) begin
      state       <= next_state;
      pixel_x     <= nx;
      pixel_y     <= ny;
      hsync       <= (go && nx >= HS_START && nx < HS_END) ? HS_POL : ~HS_POL;
      vsync       <= (go && ny >= VS_START && ny < VS_END) ? VS_POL : ~VS_POL;
      video_on    <= go && (nx < H_ACT_C) && (ny < V_ACT_C);
      line_start  <= go && (nx == '0);
      frame_start <= go && (nx == '0) && (ny == '0);
      busy        <= go;
    end
  end

`ifdef VGA_FRAME_CNT_EN
  // Counts every arrival at (0,0), both IDLE->RUN entry and frame wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= '0;
    end else if (pix_ce && go && nx == '0 && ny == '0) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

endmodule
